// File: rtl/alu_sequencer_if.sv
// Board-side bundle for the ALU sequencer: switch inputs, ALU operand/result
// wires, and display/status outputs.
interface alu_sequencer_if #(
    parameter int unsigned largo = 16
);
    logic [largo-1:0] data_in;
    logic [2:0]       op_in;
    logic             enter;
    logic             clear;
    logic [largo-1:0] alu_result;
    logic [largo-1:0] alu_a;
    logic [largo-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [largo-1:0] display;
    logic [2:0]       state_o;
    logic             result_valid;
    logic             done;
    logic             op_error;

    // master: the board, switches and external ALU
    modport master (
        output data_in, op_in, enter, clear, alu_result,
        input  alu_a, alu_b, alu_op, display, state_o, result_valid, done, op_error
    );

    // slave: the sequencer itself
    modport slave (
        input  data_in, op_in, enter, clear, alu_result,
        output alu_a, alu_b, alu_op, display, state_o, result_valid, done, op_error
    );
endinterface

// File: rtl/alu_sequencer.sv
// Operand/opcode entry controller: collects A, B and opcode on enter presses,
// captures the external ALU result and holds it for display.
module alu_sequencer #(
    parameter int unsigned largo = 16
) (
    input logic             clk,
    input logic             reset,
    alu_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        WaitA   = 3'd0,
        WaitB   = 3'd1,
        WaitOp  = 3'd2,
        Exec    = 3'd3,
        ShowRes = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             enter_q;
    logic             ev;
    logic [largo-1:0] a_q, a_d;
    logic [largo-1:0] b_q, b_d;
    logic [largo-1:0] res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    assign ev = bus.enter & ~enter_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = 1'b0;
        // clear outranks ev; data registers are left alone
        if (bus.clear) begin
            state_d = WaitA;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                WaitA: if (ev) begin
                    a_d     = bus.data_in;
                    state_d = WaitB;
                end
                WaitB: if (ev) begin
                    b_d     = bus.data_in;
                    state_d = WaitOp;
                end
                WaitOp: if (ev) begin
                    op_d    = bus.op_in;
                    err_d   = (bus.op_in == 3'd3) || (bus.op_in >= 3'd6);
                    state_d = Exec;
                end
                Exec: begin
                    res_d   = bus.alu_result;
                    state_d = ShowRes;
                    done_d  = 1'b1;
                end
                ShowRes: if (ev) begin
                    err_d   = 1'b0;
                    state_d = WaitA;
                end
                default: state_d = WaitA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WaitA;
            enter_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= bus.enter;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        case (state_q)
            WaitOp:        bus.display = {{(largo-3){1'b0}}, bus.op_in};
            Exec, ShowRes: bus.display = res_q;
            default:       bus.display = bus.data_in;
        endcase
    end

    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.state_o      = state_q;
    assign bus.result_valid = (state_q == ShowRes);
    assign bus.done         = done_q;
    assign bus.op_error     = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: directed entry sequences with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_alu_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.largo(W)) bus ();

    alu_sequencer #(.largo(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External ALU stand-in
    function automatic logic [W-1:0] tb_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a * b;
            3'd2:    return a & b;
            3'd4:    return a - b;
            3'd5:    return a | b;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = tb_alu(bus.alu_a, bus.alu_b, bus.alu_op);

    // Reference arithmetic in plain integers
    function automatic longint ref_res(input longint a, input longint b, input int op);
        case (op)
            0:       return (a + b) % 65536;
            1:       return (a * b) % 65536;
            2:       return a & b;
            4:       return (a - b + 65536) % 65536;
            5:       return a | b;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: phase 0..4 = waiting for A, B, op, executing, showing
    int     m_phase = 0;
    longint m_a = 0, m_b = 0, m_res = 0;
    int     m_op = 0;
    bit     m_err = 0, m_done = 0, m_prev = 0;

    always @(posedge clk) begin
        bit ev;
        ev = bus.enter && !m_prev;
        m_prev = reset ? 1'b0 : bus.enter;
        if (reset) begin
            m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_done = 0;
        end else if (bus.clear) begin
            m_phase = 0; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_phase == 3) begin
                m_res = ref_res(m_a, m_b, m_op);
                m_phase = 4;
                m_done = 1;
            end else if (ev) begin
                if (m_phase == 0) m_a = bus.data_in;
                else if (m_phase == 1) m_b = bus.data_in;
                else if (m_phase == 2) begin
                    m_op = bus.op_in;
                    m_err = (m_op == 3) || (m_op >= 6);
                end else m_err = 0;
                m_phase = (m_phase == 4) ? 0 : m_phase + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            longint d;
            d = (m_phase < 2) ? longint'(bus.data_in) :
                (m_phase == 2) ? longint'(bus.op_in) : m_res;
            cmp("m_alu_a", 32'(bus.alu_a), 32'(m_a));
            cmp("m_alu_b", 32'(bus.alu_b), 32'(m_b));
            cmp("m_alu_op", 32'(bus.alu_op), 32'(m_op));
            cmp("m_state", 32'(bus.state_o), 32'(m_phase));
            cmp("m_valid", 32'(bus.result_valid), 32'(m_phase == 4));
            cmp("m_done", 32'(bus.done), 32'(m_done));
            cmp("m_err", 32'(bus.op_error), 32'(m_err));
            cmp("m_display", 32'(bus.display), 32'(d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [W-1:0] v);
        bus.data_in = v;
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] exp, input bit exp_err);
        press(a);
        press(b);
        bus.op_in = op;
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        cmp("exec_state", 32'(bus.state_o), 32'd3);
        cmp("exec_done", 32'(bus.done), 32'd0);
        tick();
        cmp("show_done", 32'(bus.done), 32'd1);
        cmp("show_valid", 32'(bus.result_valid), 32'd1);
        cmp("show_display", 32'(bus.display), 32'(exp));
        cmp("show_err", 32'(bus.op_error), 32'(exp_err));
        tick();
        cmp("done_pulse_end", 32'(bus.done), 32'd0);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        cmp("return_state", 32'(bus.state_o), 32'd0);
        cmp("return_err", 32'(bus.op_error), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.data_in = 16'h0077;
        bus.op_in = 3'd0;
        bus.enter = 1'b1;
        bus.clear = 1'b0;
        tick();
        chk_en = 1'b1;
        cmp("rst_state", 32'(bus.state_o), 32'd0);
        cmp("rst_display", 32'(bus.display), 32'h0077);
        cmp("rst_alu_a", 32'(bus.alu_a), 32'd0);
        tick();
        // enter already high when reset releases: one ev
        reset = 1'b0;
        tick();
        cmp("rel_state", 32'(bus.state_o), 32'd1);
        cmp("rel_alu_a", 32'(bus.alu_a), 32'h0077);
        bus.enter = 1'b0;
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();

        do_op(16'd5, 16'd3, 3'd0, 16'd8, 1'b0);
        do_op(16'd300, 16'd300, 3'd1, 16'd24464, 1'b0);
        do_op(16'd3, 16'd5, 3'd4, 16'hFFFE, 1'b0);
        do_op(16'hF0F0, 16'h0FF0, 3'd5, 16'hFFF0, 1'b0);
        do_op(16'd7, 16'd5, 3'd3, 16'd0, 1'b1);

        // enter held high for 50 cycles loads A once
        bus.data_in = 16'h1234;
        bus.enter = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            bus.data_in = W'($urandom);
            tick();
        end
        cmp("hold_state", 32'(bus.state_o), 32'd1);
        cmp("hold_alu_a", 32'(bus.alu_a), 32'h1234);
        bus.enter = 1'b0;
        tick();
        bus.data_in = 16'hBEEF;
        bus.enter = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        cmp("clr_state", 32'(bus.state_o), 32'd0);
        cmp("clr_alu_b", 32'(bus.alu_b), 32'd5);
        tick();

        // reset while in EXEC
        press(16'h0011);
        press(16'h0022);
        bus.op_in = 3'd0;
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        cmp("rx_exec", 32'(bus.state_o), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("rx_state", 32'(bus.state_o), 32'd0);
        cmp("rx_alu_a", 32'(bus.alu_a), 32'd0);
        cmp("rx_alu_b", 32'(bus.alu_b), 32'd0);
        cmp("rx_done", 32'(bus.done), 32'd0);
        cmp("rx_display", 32'(bus.display), 32'h0022);
        tick();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) bus.enter = ~bus.enter;
            bus.data_in = W'($urandom);
            bus.op_in = 3'($urandom_range(0, 7));
            bus.clear = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        bus.clear = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Operand/opcode entry controller for the shared 16-bit ALU datapath in the lab calculator.
- Collects operand A, operand B and a 3-bit opcode from switches, one per enter press.
- Drives the external ALU instance combinationally from internal registers, captures its result in a register, and holds it for display.
- Sits between the debounced board inputs and the display driver; the ALU itself stays a separate instance.

Parameters:
- largo, 16, operand/result width in bits; must match the connected ALU.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_in  in  largo  operand switches
- op_in  in  3  opcode switches: 0 add, 1 mul, 2 and, 4 sub, 5 or
- enter  in  1  debounced level; the block acts on its 0->1 transition
- clear  in  1  synchronous abort back to WAIT_A
- alu_result  in  largo  combinational result from the ALU
- alu_a  out  largo  operand A register, drives the ALU
- alu_b  out  largo  operand B register, drives the ALU
- alu_op  out  3  opcode register, drives the ALU
- display  out  largo  value for the display driver
- state_o  out  3  current state code
- result_valid  out  1  high while in SHOW_RES
- done  out  1  one-cycle pulse on entry to SHOW_RES
- op_error  out  1  registered; latched opcode is unsupported (3, 6 or 7)

Behaviour:
- Edge detect:
  - enter_q is a register holding enter; ev = enter & ~enter_q.
  - Enter held high for any length produces exactly one ev.
  - enter_q resets to 0, so enter already high at reset release produces one ev.
- States and codes: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW_RES=4.
- Transitions:
  - WAIT_A + ev: a_reg<=data_in, go to WAIT_B.
  - WAIT_B + ev: b_reg<=data_in, go to WAIT_OP.
  - WAIT_OP + ev: op_reg<=op_in; op_error<=(op_in is 3, 6 or 7); go to EXEC.
  - EXEC, unconditional, one cycle: res_reg<=alu_result, go to SHOW_RES.
  - SHOW_RES + ev: go to WAIT_A. a_reg, b_reg, op_reg and res_reg keep their values; op_error clears.
  - Any state not listed above with ev: hold the current state.
- Latency: ev sampled in WAIT_OP at cycle n -> EXEC at n+1 -> SHOW_RES and done=1 at n+2. done is 0 at n+3 onward.
- ev arriving during EXEC is ignored; it is not queued.
- alu_a/alu_b/alu_op = a_reg/b_reg/op_reg at all times.
- Arithmetic:
  - The block adds no logic; res_reg takes the ALU's largo-bit result unchanged (mul keeps the low largo bits; sub wraps modulo 2^largo).
  - Unsupported op: the ALU returns 0 and res_reg=0, with op_error=1.
- display:
  - data_in in WAIT_A and WAIT_B.
  - {zeros, op_in} in WAIT_OP.
  - res_reg in EXEC and SHOW_RES.
- clear: from any state, go to WAIT_A and clear op_error and done. Data registers are untouched.
- reset: all registers are 0, state is WAIT_A, and every output is 0 except display, which equals data_in.
- Priority: reset > clear > ev. reset or clear in the same cycle as ev discards the ev.
- Reset mid-EXEC: res_reg is not updated and the next state is WAIT_A.
- state_o codes 5-7 are unreachable; if entered, the next state is WAIT_A.

Test Plan:
- A=5, B=3, op=0 via three enter pulses:
  - done exactly 2 cycles after the third ev;
  - display=8, result_valid=1, op_error=0.
- A=300, B=300, op=1 -> display=24464 (90000 mod 65536).
- A=3, B=5, op=4 -> display=0xFFFE. Then A=0xF0F0, B=0x0FF0, op=5 -> display=0xFFF0.
- op=3 -> result_valid=1, display=0, op_error=1. The next ev clears op_error and returns to WAIT_A.
- Enter held high 50 cycles in WAIT_A -> only a_reg loads; state stays WAIT_B.
  - clear asserted together with an ev in WAIT_B -> WAIT_A; b_reg unchanged.
- reset asserted during EXEC -> next cycle: state_o=0, all registers 0, done=0; res_reg not loaded.
